game_ctrl_fsm: RTL and testbench

Parametrised top-level game controller for the STG shooter. It sequences boot, title, play, hit-invulnerability, bomb, pause and game-over phases, and it owns the life and bomb counters. It drives `game_en` and a one-cycle `game_reset` to the player, enemy, bullet and render blocks. Compared with the previous controller it adds pause/resume, extra-life events, bomb-stock consumption with a refill on death, saturating counters and configurable timings/widths.

---
 rtl/game_ctrl_fsm_pkg.sv | 22 ++
 rtl/game_ctrl_fsm_btn_edge.sv | 21 ++
 rtl/game_ctrl_fsm.sv | 155 +++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_fsm_pkg.sv
// Shared definitions for the STG game controller: state encodings,
// default phase timings and small helpers.
package game_ctrl_fsm_pkg;

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_TITLE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_HIT   = 3'd3;
  localparam logic [2:0] ST_BOMB  = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;
  localparam logic [2:0] ST_OVER  = 3'd6;

  localparam int DEF_BOOT_TICKS = 20_000_000;
  localparam int DEF_HIT_TICKS  = 200_000_000;
  localparam int DEF_BOMB_TICKS = 400_000_000;

  // States in which the game world advances and extra lives are honoured.
  function automatic logic is_world(input logic [2:0] st);
    return (st == ST_PLAY) || (st == ST_HIT) || (st == ST_BOMB);
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_btn_edge.sv
// Rising-edge detector for one debounced button. The history register resets
// to RST_VAL so a button held through reset does not fire.
module btn_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic hard_reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (hard_reset) prev <= RST_VAL;
    else            prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Top-level game controller: phase FSM, phase timer, life/bomb counters and
// the enable/reset strobes for the world blocks. All outputs are registered.
module game_ctrl_fsm
  import game_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int LIFE_INIT  = 3,
  parameter int BOMB_INIT  = 3,
  parameter int LIFE_MAX   = 9,
  parameter int TMR_W      = 32,
  parameter int BOOT_TICKS = DEF_BOOT_TICKS,
  parameter int HIT_TICKS  = DEF_HIT_TICKS,
  parameter int BOMB_TICKS = DEF_BOMB_TICKS
) (
  input  logic             clk,
  input  logic             hard_reset,
  input  logic             enter,
  input  logic             bomb,
  input  logic             pause,
  input  logic             collision,
  input  logic             extend,
  output logic [CNT_W-1:0] num_life,
  output logic [CNT_W-1:0] num_bomb,
  output logic [2:0]       game_state,
  output logic             game_en,
  output logic             game_reset,
  output logic             invuln,
  output logic             bomb_active
);

  localparam logic [TMR_W-1:0] BOOT_LOAD = TMR_W'(BOOT_TICKS - 1);
  localparam logic [TMR_W-1:0] HIT_LOAD  = TMR_W'(HIT_TICKS - 1);
  localparam logic [TMR_W-1:0] BOMB_LOAD = TMR_W'(BOMB_TICKS - 1);
  localparam logic [CNT_W-1:0] LIFE_INIT_C = CNT_W'(LIFE_INIT);
  localparam logic [CNT_W-1:0] BOMB_INIT_C = CNT_W'(BOMB_INIT);
  localparam logic [CNT_W-1:0] LIFE_MAX_C  = CNT_W'(LIFE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic enter_rise, bomb_rise, pause_rise;

  btn_edge #(.RST_VAL(1'b1)) u_enter_edge (
    .clk(clk), .hard_reset(hard_reset), .level(enter), .rise(enter_rise));
  btn_edge #(.RST_VAL(1'b1)) u_bomb_edge (
    .clk(clk), .hard_reset(hard_reset), .level(bomb), .rise(bomb_rise));
  btn_edge #(.RST_VAL(1'b1)) u_pause_edge (
    .clk(clk), .hard_reset(hard_reset), .level(pause), .rise(pause_rise));

  logic [2:0]       state, state_n, ret_state, ret_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] life_n, bomb_n, life_ext;
  logic             reset_n, bomb_ok, timer_done;

  assign life_ext   = (num_life >= LIFE_MAX_C) ? num_life : num_life + CNT_ONE;
  assign bomb_ok    = bomb_rise && (num_bomb != '0);
  assign timer_done = (timer == '0);

  always_comb begin
    state_n = state;
    ret_n   = ret_state;
    timer_n = timer;
    life_n  = num_life;
    bomb_n  = num_bomb;
    reset_n = 1'b0;
    if (extend && is_world(state)) life_n = life_ext;
    case (state)
      ST_BOOT: begin
        if (timer_done) state_n = ST_TITLE;
        else            timer_n = timer - TMR_W'(1);
      end
      ST_TITLE: begin
        if (enter_rise) begin
          state_n = ST_PLAY;
          reset_n = 1'b1;
          life_n  = LIFE_INIT_C;
          bomb_n  = BOMB_INIT_C;
        end
      end
      ST_PLAY: begin
        if (pause_rise) begin
          ret_n   = ST_PLAY;
          state_n = ST_PAUSE;
        end else if (bomb_ok) begin
          state_n = ST_BOMB;
          bomb_n  = num_bomb - CNT_ONE;
          timer_n = BOMB_LOAD;
        end else if (collision) begin
          if (num_life <= CNT_ONE) begin
            // Fatal hit wins over a coincident extend.
            state_n = ST_OVER;
            life_n  = '0;
          end else begin
            state_n = ST_HIT;
            life_n  = extend ? num_life : num_life - CNT_ONE;
            bomb_n  = BOMB_INIT_C;
            timer_n = HIT_LOAD;
          end
        end
      end
      ST_HIT, ST_BOMB: begin
        if (pause_rise) begin
          // The entry cycle counts toward the phase; a phase that has just
          // run out resumes straight into PLAY.
          state_n = ST_PAUSE;
          ret_n   = timer_done ? ST_PLAY : state;
          if (!timer_done) timer_n = timer - TMR_W'(1);
        end else if (state == ST_HIT && bomb_ok) begin
          state_n = ST_BOMB;
          bomb_n  = num_bomb - CNT_ONE;
          timer_n = BOMB_LOAD;
        end else if (timer_done) begin
          state_n = ST_PLAY;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      ST_PAUSE: begin
        if (pause_rise) state_n = ret_state;
      end
      ST_OVER: begin
        if (enter_rise) state_n = ST_TITLE;
      end
      default: begin
        state_n = ST_BOOT;
        timer_n = BOOT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state       <= ST_BOOT;
      ret_state   <= ST_PLAY;
      timer       <= BOOT_LOAD;
      num_life    <= LIFE_INIT_C;
      num_bomb    <= BOMB_INIT_C;
      game_en     <= 1'b0;
      game_reset  <= 1'b0;
      invuln      <= 1'b0;
      bomb_active <= 1'b0;
    end else begin
      state       <= state_n;
      ret_state   <= ret_n;
      timer       <= timer_n;
      num_life    <= life_n;
      num_bomb    <= bomb_n;
      game_en     <= is_world(state_n);
      game_reset  <= reset_n;
      invuln      <= (state_n == ST_HIT) || (state_n == ST_BOMB);
      bomb_active <= (state_n == ST_BOMB);
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm: a vector table for the main flow plus
// hand-written sequences for pause, bomb exhaustion, game over and reset.
module tb_game_ctrl_fsm;

  localparam int CNT_W = 4;
  localparam int BOOT_T = 4;
  localparam int HIT_T  = 5;
  localparam int BOMB_T = 8;

  localparam logic [2:0] BOOT = 3'd0, TITLE = 3'd1, PLAY = 3'd2, HIT = 3'd3,
                         BMB = 3'd4, PAUSE = 3'd5, OVER = 3'd6;

  logic clk = 1'b0;
  logic hard_reset, enter, bomb, pause, collision, extend;
  logic [CNT_W-1:0] num_life, num_bomb;
  logic [2:0] game_state;
  logic game_en, game_reset, invuln, bomb_active;

  game_ctrl_fsm #(
    .CNT_W(CNT_W), .LIFE_INIT(3), .BOMB_INIT(3), .LIFE_MAX(9), .TMR_W(32),
    .BOOT_TICKS(BOOT_T), .HIT_TICKS(HIT_T), .BOMB_TICKS(BOMB_T)
  ) dut (
    .clk(clk), .hard_reset(hard_reset), .enter(enter), .bomb(bomb),
    .pause(pause), .collision(collision), .extend(extend),
    .num_life(num_life), .num_bomb(num_bomb), .game_state(game_state),
    .game_en(game_en), .game_reset(game_reset), .invuln(invuln),
    .bomb_active(bomb_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e, b, p, c, x;
    logic [2:0] st;
    logic [CNT_W-1:0] life, bmb;
    logic en, rst, inv, ba;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  task automatic add(input logic e, b, p, c, x, input logic [2:0] st,
                     input int life, input int bmb,
                     input logic en, rst, inv, ba);
    vec_t v;
    v.e = e; v.b = b; v.p = p; v.c = c; v.x = x; v.st = st;
    v.life = CNT_W'(life); v.bmb = CNT_W'(bmb);
    v.en = en; v.rst = rst; v.inv = inv; v.ba = ba;
    vq.push_back(v);
  endtask

  task automatic drive(input logic e, b, p, c, x);
    enter = e; bomb = b; pause = p; collision = c; extend = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [2:0] st,
                           input int life, input int bmb,
                           input logic en, rst, inv, ba);
    logic [14:0] act, exp;
    act = {game_state, num_life, num_bomb, game_en, game_reset, invuln, bomb_active};
    exp = {st, CNT_W'(life), CNT_W'(bmb), en, rst, inv, ba};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d life=%0d bomb=%0d en/rst/inv/ba=%b want st=%0d life=%0d bomb=%0d en/rst/inv/ba=%b",
               name, act[14:12], act[11:8], act[7:4], act[3:0],
               exp[14:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    int n = 0;
    while (game_state !== st && n < budget) begin
      tick();
      n++;
    end
    check_val(name, int'(game_state), int'(st));
  endtask

  initial begin
    // e b p c x | state life bomb en rst inv ba
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, BOOT, 3,3, 0,0,0,0);
    add(1,0,0,0,0, TITLE,3,3, 0,0,0,0);
    add(1,0,0,0,0, TITLE,3,3, 0,0,0,0);
    add(0,0,0,0,0, TITLE,3,3, 0,0,0,0);
    add(1,0,0,0,0, PLAY, 3,3, 1,1,0,0);
    add(1,0,0,0,0, PLAY, 3,3, 1,0,0,0);
    add(1,0,0,0,0, PLAY, 3,3, 1,0,0,0);
    add(0,0,0,0,0, PLAY, 3,3, 1,0,0,0);
    add(0,0,0,1,0, HIT,  2,3, 1,0,1,0);
    add(0,0,0,1,0, HIT,  2,3, 1,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, HIT, 2,3, 1,0,1,0);
    add(0,0,0,0,0, PLAY, 2,3, 1,0,0,0);
    add(0,1,0,1,0, BMB,  2,2, 1,0,1,1);
    for (int i = 0; i < 7; i++) add(0,1,0,0,0, BMB, 2,2, 1,0,1,1);
    add(0,1,0,0,0, PLAY, 2,2, 1,0,0,0);
    add(0,0,0,0,0, PLAY, 2,2, 1,0,0,0);

    // Buttons held through reset must not fire afterwards.
    hard_reset = 1'b1;
    drive(1,1,1,0,0);
    tick(); tick();
    check_all("reset", BOOT, 3,3, 0,0,0,0);
    hard_reset = 1'b0;
    drive(1,0,0,0,0);

    foreach (vq[i]) begin
      drive(vq[i].e, vq[i].b, vq[i].p, vq[i].c, vq[i].x);
      tick();
      check_all($sformatf("vec[%0d]", i), vq[i].st, int'(vq[i].life),
                int'(vq[i].bmb), vq[i].en, vq[i].rst, vq[i].inv, vq[i].ba);
    end

    // Pause in BOMB with 3 cycles left, frozen for 10 cycles.
    drive(0,1,0,0,0); tick();
    check_all("bomb2", BMB, 2,1, 1,0,1,1);
    drive(0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("bomb_run", BMB, 2,1, 1,0,1,1);
    end
    drive(0,0,1,0,0); tick();
    check_all("pause_in", PAUSE, 2,1, 0,0,0,0);
    for (int i = 0; i < 9; i++) begin
      drive(0, i == 3, 0, i == 3, 0);
      tick();
      check_all("pause_hold", PAUSE, 2,1, 0,0,0,0);
    end
    drive(0,0,1,0,0); tick();
    check_all("pause_out", BMB, 2,1, 1,0,1,1);
    drive(0,0,0,0,0);
    tick(); check_all("resume1", BMB, 2,1, 1,0,1,1);
    tick(); check_all("resume2", BMB, 2,1, 1,0,1,1);
    tick(); check_all("resume_exit", PLAY, 2,1, 1,0,0,0);

    // Empty the stock, then a bomb press does nothing.
    drive(0,1,0,0,0); tick();
    check_all("bomb_last", BMB, 2,0, 1,0,1,1);
    drive(0,0,0,0,0);
    wait_state("bomb_last_exit", PLAY, 20);
    drive(0,1,0,0,0); tick();
    check_all("bomb_empty", PLAY, 2,0, 1,0,0,0);
    drive(0,0,0,0,0); tick();
    drive(0,0,0,1,0); tick();
    check_all("hit_refill", HIT, 1,3, 1,0,1,0);
    drive(0,0,0,0,0);
    wait_state("hit_exit", PLAY, 20);
    drive(0,0,0,1,1); tick();
    check_all("fatal_extend", OVER, 0,3, 0,0,0,0);
    drive(0,0,0,0,0); tick();
    drive(1,0,0,0,0); tick();
    check_all("over_title", TITLE, 0,3, 0,0,0,0);
    drive(0,0,0,0,0); tick();
    drive(1,0,0,0,0); tick();
    check_all("restart", PLAY, 3,3, 1,1,0,0);

    // Extend + non-fatal collision, saturation, pause priority, hard reset.
    drive(0,0,0,1,1); tick();
    check_all("hit_extend", HIT, 3,3, 1,0,1,0);
    drive(0,0,0,0,1);
    for (int i = 0; i < 6; i++) tick();
    check_val("extend_to_max", int'(num_life), 9);
    tick();
    check_val("extend_sat", int'(num_life), 9);
    check_val("extend_sat_state", int'(game_state), int'(PLAY));
    drive(0,0,1,1,0); tick();
    check_all("pause_over_hit", PAUSE, 9,3, 0,0,0,0);
    drive(0,0,0,0,0); tick();
    drive(0,0,1,0,0); tick();
    check_all("pause_play_back", PLAY, 9,3, 1,0,0,0);
    drive(0,0,0,1,0); tick();
    check_all("hit_again", HIT, 8,3, 1,0,1,0);
    drive(0,0,0,0,0);
    hard_reset = 1'b1; tick();
    check_all("hard_reset_hit", BOOT, 3,3, 0,0,0,0);
    hard_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
